dff_pipe: RTL
=============

// Module: dff_pipe
// PURPOSE
//  Parametrised elastic register pipeline: the successor to the single Dff.
//  Carries WIDTH-bit data through DEPTH register stages with a valid/ready handshake.
//  Stalled stages hold their data, and empty stages (bubbles) are collapsed.
//  Supports synchronous flush and reports occupancy.
//  Used to retime long datapaths between handshaked blocks without losing throughput.
// PARAMETERS
//  WIDTH     8  data width in bits (>=1)
//  DEPTH     3  number of register stages (>=1); nominal latency in cycles
//  RESET_VAL 0  value loaded into every data register on reset (WIDTH bits)
// PORTS
//  clk        in   1                   clock; all state updates on posedge
//  rst_n      in   1                   asynchronous, active-low reset
//  flush      in   1                   synchronous clear of all stages
//  in_valid   in   1                   upstream data valid
//  in_data    in   WIDTH               upstream data
//  in_ready   out  1                   pipeline can accept in_data this cycle
//  out_valid  out  1                   last stage holds valid data
//  out_data   out  WIDTH               last-stage data
//  out_ready  in   1                   downstream accepts out_data this cycle
//  count      out  $clog2(DEPTH+1)     number of valid stages
// BEHAVIOUR
//  - State: per stage i (0..DEPTH-1), a valid bit v[i] and a data register q[i].
//    Stage DEPTH-1 drives out_valid and out_data.
//  - Reset (rst_n=0, asynchronous): all v[i]=0 and all q[i]=RESET_VAL.
//    Outputs during reset: out_valid=0, out_data=RESET_VAL, count=0, in_ready=0.
//    Reset asserted mid-transfer discards all contents immediately.
//  - Ready chain (combinational):
//    - rdy[DEPTH] = out_ready
//    - rdy[i] = !v[i] | rdy[i+1]
//    - in_ready = rdy[0] & !flush & rst_n
//  - Stage update on posedge, for i>0:
//    - If rdy[i]: v[i] <= v[i-1]; q[i] <= q[i-1] when v[i-1]=1, else q[i] holds.
//    - Otherwise the stage holds.
//  - Stage 0 update on posedge:
//    - If rdy[0]: v[0] <= in_valid & in_ready; q[0] <= in_data on accept.
//  - Transfers: an input transfer is in_valid & in_ready; an output transfer is out_valid & out_ready.
//  - Latency: with no stalls, data accepted at edge N appears on out_data after edge N+DEPTH-1.
//    Throughput is 1 item/cycle.
//  - Bubble collapse: a stalled output never blocks a stage that has an empty stage downstream.
//  - Full (count=DEPTH):
//    - in_ready=out_ready, so push and pop in the same cycle keep count=DEPTH.
//  - Empty (count=0):
//    - out_valid=0 and in_ready=1 (if flush=0).
//  - flush=1: at the next posedge all v[i]=0 and count=0. Data registers hold.
//    - in_ready=0 during flush, so no input is accepted.
//    - An out_valid&out_ready transfer in the flush cycle still counts as delivered.
//    - rst_n takes priority over flush.
//  - count: registered popcount of v[]; it changes only on posedge or on reset.
//  - Data stability: out_data is stable while out_valid=1 and out_ready=0.
//  - No combinational path from in_data to out_data.
//  - Combinational paths exist from out_ready to in_ready only.
//  - Assertions: in_ready=0 whenever count=DEPTH and out_ready=0.
//    out_valid must not drop without an output transfer or flush.
// TESTING  (WIDTH=8, DEPTH=3, RESET_VAL=8'h00 unless noted)
//  1 Reset: stream 3 items, drop rst_n between edges -> out_valid=0, count=0, out_data=8'h00
//    at once, no clock needed.
//  2 Stream: in_valid=1 with 8'h01..8'h08 each cycle, out_ready=1 -> 8'h01 seen after 2 more
//    edges, then one item per cycle, in order, none lost.
//  3 Backpressure: out_ready=0, offer 8'hA1..8'hA4 -> A1..A3 accepted, count=3, in_ready=0.
//    Then out_ready=1 for one cycle -> A1 out and A4 accepted in the same cycle, count stays 3.
//  4 Bubble collapse: out_ready=0; push 8'h11, idle 2 cycles, push 8'h22 -> both accepted, count=2.
//    Then out_ready=1 -> 8'h11 then 8'h22 on consecutive cycles.
//  5 Flush: count=3, assert flush with in_valid=1, in_data=8'hFF -> in_ready=0.
//    Next cycle count=0 and out_valid=0; 8'hFF never emerges.
//  6 Random: random in_valid/out_ready at 50% over 10k cycles against a queue scoreboard
//    -> order and data match, count never exceeds 3, all assertions hold; repeat with DEPTH=1.

Source files
------------

// File: rtl/dff_pipe.sv
// dff_pipe: elastic register pipeline with valid/ready handshake.
// Carries WIDTH-bit data through DEPTH register stages. A stalled stage
// holds its data, and empty stages (bubbles) are filled by the stage behind
// them even while the output is stalled. Synchronous flush clears all valid
// bits. count is a registered popcount of the stage valid bits.
//
// Ports:
//   clk        clock, all state updates on posedge
//   rst_n      asynchronous active-low reset
//   flush      synchronous clear of all stage valid bits
//   in_valid   upstream data valid
//   in_data    upstream data (WIDTH)
//   in_ready   pipeline accepts in_data this cycle (combinational from out_ready)
//   out_valid  last stage holds valid data
//   out_data   last-stage data (WIDTH)
//   out_ready  downstream accepts out_data this cycle
//   count      number of valid stages ($clog2(DEPTH+1))
module dff_pipe #(
  parameter int unsigned       WIDTH     = 8,
  parameter int unsigned       DEPTH     = 3,
  parameter logic [WIDTH-1:0]  RESET_VAL = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic                           in_valid,
  input  logic [WIDTH-1:0]               in_data,
  output logic                           in_ready,
  output logic                           out_valid,
  output logic [WIDTH-1:0]               out_data,
  input  logic                           out_ready,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic [DEPTH-1:0] r_v;
  logic [WIDTH-1:0] r_q [DEPTH];
  logic [CW-1:0]    r_count;

  logic [DEPTH-1:0] w_rdy;
  logic [DEPTH-1:0] w_v_nxt;
  logic [CW-1:0]    w_count_nxt;
  logic             w_in_xfer;
  logic             w_acc;

  // Stage i may load when it, or any stage downstream of it, is empty,
  // or when the output is being drained.
  always_comb begin
    w_rdy = '0;
    w_acc = out_ready;
    for (int i = int'(DEPTH) - 1; i >= 0; i--) begin
      w_acc    = w_acc | ~r_v[i];
      w_rdy[i] = w_acc;
    end
  end

  assign in_ready  = w_rdy[0] & ~flush & rst_n;
  assign w_in_xfer = in_valid & in_ready;

  // Next valid bits and their popcount.
  always_comb begin
    w_v_nxt     = r_v;
    w_count_nxt = '0;
    if (w_rdy[0]) begin
      w_v_nxt[0] = w_in_xfer;
    end
    for (int i = 1; i < int'(DEPTH); i++) begin
      if (w_rdy[i]) begin
        w_v_nxt[i] = r_v[i-1];
      end
    end
    if (flush) begin
      w_v_nxt = '0;
    end
    for (int i = 0; i < int'(DEPTH); i++) begin
      w_count_nxt = w_count_nxt + CW'(w_v_nxt[i]);
    end
  end

  // Valid bits and occupancy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v     <= '0;
      r_count <= '0;
    end else begin
      r_v     <= w_v_nxt;
      r_count <= w_count_nxt;
    end
  end

  // Data registers only load when valid data moves in; flush leaves them alone.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        r_q[i] <= RESET_VAL;
      end
    end else if (!flush) begin
      if (w_in_xfer) begin
        r_q[0] <= in_data;
      end
      for (int i = 1; i < int'(DEPTH); i++) begin
        if (w_rdy[i] && r_v[i-1]) begin
          r_q[i] <= r_q[i-1];
        end
      end
    end
  end

  assign out_valid = r_v[DEPTH-1];
  assign out_data  = r_q[DEPTH-1];
  assign count     = r_count;

endmodule
